// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-back record per request into an ASCII trace line, one char per cycle.
// Optional expected-flag outputs for the trace checker are compiled in with EMITTER_ERRFLAG_EN.
//
// state | meaning
// IDLE  | waiting for a record, in_ready high
// CONV  | 16-cycle double-dabble of time and grf into BCD
// EMIT  | streaming the frame characters through the out_valid/out_ready handshake
module cpu_trace_emitter #(
  parameter int PAD_SPACES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_type,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [13:0] in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
`ifdef EMITTER_ERRFLAG_EN
  ,
  input  logic [15:0] freq,
  output logic [1:0]  exp_format,
  output logic [3:0]  exp_error
`endif
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
  typedef enum logic [3:0] {
    SG_CARET, SG_TIME, SG_AT, SG_PC, SG_COLON, SG_PAD1, SG_TYPE,
    SG_FIELD, SG_PAD2, SG_LT, SG_EQ, SG_PAD3, SG_DATA, SG_HASH
  } seg_t;

  localparam logic [2:0] PAD_LAST = (PAD_SPACES > 0) ? 3'(PAD_SPACES - 1) : 3'd0;

  state_t      state, state_nxt;
  seg_t        seg, seg_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [3:0]  conv_cnt;
  logic        type_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [31:0] t_sr, g_sr;
  logic [15:0] t_bcd, g_bcd;
  logic [2:0]  t_last, g_last;
  logic [31:0] sel_word;
  logic [3:0]  nib;
  logic [7:0]  hex_char, emit_char;
  logic [15:0] t_sat;
  logic [13:0] g_sat;
  logic        accept, advance;

  // Upper half holds the BCD digits, lower half the binary still to be shifted in.
  function automatic logic [31:0] dd_step(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < 4; i++) begin
      if (y[16+4*i +: 4] >= 4'd5) y[16+4*i +: 4] = y[16+4*i +: 4] + 4'd3;
    end
    return {y[30:0], 1'b0};
  endfunction

  assign t_sat   = (in_time > 16'd9999) ? 16'd9999 : in_time;
  assign g_sat   = (in_grf > 14'd9999) ? 14'd9999 : in_grf;
  assign accept  = (state == IDLE) && in_valid;
  assign advance = (state == EMIT) && out_ready;
  assign t_bcd   = t_sr[31:16];
  assign g_bcd   = g_sr[31:16];

  // Index of the most significant non-zero digit; a zero value still prints one digit.
  assign t_last = (t_bcd[15:12] != 4'd0) ? 3'd3 : (t_bcd[11:8] != 4'd0) ? 3'd2 :
                  (t_bcd[7:4] != 4'd0) ? 3'd1 : 3'd0;
  assign g_last = (g_bcd[15:12] != 4'd0) ? 3'd3 : (g_bcd[11:8] != 4'd0) ? 3'd2 :
                  (g_bcd[7:4] != 4'd0) ? 3'd1 : 3'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CONV;
      CONV:    if (conv_cnt == 4'd0) state_nxt = EMIT;
      EMIT:    if (out_ready && seg == SG_HASH) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_char   = 8'h00;
    frame_done = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid  = 1'b1;
        out_char   = emit_char;
        frame_done = out_ready && (seg == SG_HASH);
      end
      default: ;
    endcase
  end

  always_comb begin
    seg_nxt = SG_CARET;
    cnt_nxt = 3'd0;
    case (seg)
      SG_CARET: begin seg_nxt = SG_TIME; cnt_nxt = t_last; end
      SG_TIME:  seg_nxt = SG_AT;
      SG_AT:    begin seg_nxt = SG_PC; cnt_nxt = 3'd7; end
      SG_PC:    seg_nxt = SG_COLON;
      SG_COLON: begin
        if (PAD_SPACES != 0) begin seg_nxt = SG_PAD1; cnt_nxt = PAD_LAST; end
        else seg_nxt = SG_TYPE;
      end
      SG_PAD1:  seg_nxt = SG_TYPE;
      SG_TYPE:  begin seg_nxt = SG_FIELD; cnt_nxt = type_q ? 3'd7 : g_last; end
      SG_FIELD: begin
        if (PAD_SPACES != 0) begin seg_nxt = SG_PAD2; cnt_nxt = PAD_LAST; end
        else seg_nxt = SG_LT;
      end
      SG_PAD2:  seg_nxt = SG_LT;
      SG_LT:    seg_nxt = SG_EQ;
      SG_EQ: begin
        if (PAD_SPACES != 0) begin seg_nxt = SG_PAD3; cnt_nxt = PAD_LAST; end
        else begin seg_nxt = SG_DATA; cnt_nxt = 3'd7; end
      end
      SG_PAD3:  begin seg_nxt = SG_DATA; cnt_nxt = 3'd7; end
      SG_DATA:  seg_nxt = SG_HASH;
      default:  seg_nxt = SG_CARET;
    endcase
  end

  always_comb begin
    sel_word = 32'h0;
    case (seg)
      SG_TIME:  sel_word = {16'h0, t_bcd};
      SG_PC:    sel_word = pc_q;
      SG_FIELD: sel_word = type_q ? addr_q : {16'h0, g_bcd};
      SG_DATA:  sel_word = data_q;
      default:  sel_word = 32'h0;
    endcase
    nib      = 4'(sel_word >> {cnt, 2'b00});
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  end

  always_comb begin
    emit_char = 8'h00;
    case (seg)
      SG_CARET: emit_char = 8'h5e;
      SG_AT:    emit_char = 8'h40;
      SG_COLON: emit_char = 8'h3a;
      SG_TYPE:  emit_char = type_q ? 8'h2a : 8'h24;
      SG_LT:    emit_char = 8'h3c;
      SG_EQ:    emit_char = 8'h3d;
      SG_HASH:  emit_char = 8'h23;
      SG_PAD1, SG_PAD2, SG_PAD3: emit_char = 8'h20;
      SG_TIME, SG_PC, SG_FIELD, SG_DATA: emit_char = hex_char;
      default:  emit_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg      <= SG_CARET;
      cnt      <= 3'd0;
      conv_cnt <= 4'd0;
      type_q   <= 1'b0;
      pc_q     <= 32'h0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      t_sr     <= 32'h0;
      g_sr     <= 32'h0;
    end else if (accept) begin
      seg      <= SG_CARET;
      cnt      <= 3'd0;
      conv_cnt <= 4'd15;
      type_q   <= in_type;
      pc_q     <= in_pc;
      addr_q   <= in_type ? in_addr : 32'h0;
      data_q   <= in_data;
      t_sr     <= {16'h0, t_sat};
      g_sr     <= {18'h0, g_sat};
    end else if (state == CONV) begin
      t_sr     <= dd_step(t_sr);
      g_sr     <= dd_step(g_sr);
      conv_cnt <= conv_cnt - 4'd1;
    end else if (advance) begin
      if (cnt != 3'd0) cnt <= cnt - 3'd1;
      else begin
        seg <= seg_nxt;
        cnt <= cnt_nxt;
      end
    end
  end

`ifdef EMITTER_ERRFLAG_EN
  logic [3:0] err_q;
  logic [3:0] err_new;

  always_comb begin
    err_new[0] = (t_sat & ((freq >> 2) - 16'd1)) != 16'd0;
    err_new[1] = (in_pc[1:0] != 2'd0) || (in_pc < 32'h3000) || (in_pc > 32'h4fff);
    err_new[2] = in_type && ((in_addr[1:0] != 2'd0) || (in_addr > 32'h2fff));
    err_new[3] = !in_type && (g_sat > 14'd31);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_q <= 4'h0;
    else if (accept) err_q <= err_new;
  end

  assign exp_format = frame_done ? (type_q ? 2'b10 : 2'b01) : 2'b00;
  assign exp_error  = frame_done ? err_q : 4'h0;
`endif

endmodule
